// File: rtl/kolache_alu_pkg.sv
// ---------------------------------------------------------------------------
// kolache_alu_pkg
//
// Purpose : Definitions shared by the Kolache ALU serial comparator:
//           - the FSM state encoding,
//           - the default operand and digit widths,
//           - a ceil(log2) helper that sizes the digit counter.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package kolache_alu_pkg;

  // Default operand width and scan digit width for the serial comparator.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  // Comparator control states.
  // IDLE : waiting for an accepted start.
  // SCAN : walking the digits MSB-first.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Ceiling log2.
  // Used to size the digit counter from the digit count WIDTH/DIGIT.
  // Returns 0 for a value of 1; callers clamp the result to at least 1 bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage : kolache_alu_pkg

// File: rtl/digit_compare.sv
// ---------------------------------------------------------------------------
// digit_compare
//
// Purpose : Combinational unsigned compare of one DIGIT-bit digit pair.
//           Any sign handling is applied by the caller before the inputs.
// Ports   : x    [DIGIT-1:0] in   digit from operand A
//           y    [DIGIT-1:0] in   digit from operand B
//           x_gt             out  x > y (unsigned)
//           x_eq             out  x == y
// ---------------------------------------------------------------------------
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             x_gt,
  output logic             x_eq
);

  // Plain unsigned magnitude compare of the two digits.
  always_comb begin
    x_gt = (x > y);
    x_eq = (x == y);
  end

endmodule : digit_compare

// File: rtl/serial_magnitude_compare.sv
// ---------------------------------------------------------------------------
// serial_magnitude_compare
//
// Purpose : Digit-serial magnitude comparator.
//           - Latches an operand pair when start is accepted.
//           - Scans MSB-first, DIGIT bits per cycle.
//           - Stops at the first differing digit, or after the last digit.
//           Results are registered greater/less/equal flags for either
//           unsigned or two's-complement operands.
// Ports   : clk          in            rising-edge clock
//           rst          in            synchronous active-high reset
//           start        in            request; accepted while busy==0
//           signed_mode  in            1 = two's complement, 0 = unsigned
//           a, b         in  [WIDTH]   operands, sampled on accept only
//           busy         out           scan in progress
//           done         out           one-cycle pulse, flags valid
//           gt, lt, eq   out           a>b, a<b, a==b (held until next result)
// ---------------------------------------------------------------------------
module serial_magnitude_compare
  import kolache_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Number of digits per operand.
  localparam int NDIG = WIDTH / DIGIT;

  // Width of the digit counter.
  // Kept at least 1 bit wide so that a single-digit configuration still elaborates.
  localparam int KW = (clog2(NDIG) > 0) ? clog2(NDIG) : 1;

  // Index of the final (LSB) digit.
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  // Mask that flips the top bit of a digit.
  // In signed mode this maps the sign digit to offset binary, so that the
  // unsigned digit compare orders negative operands below positive ones.
  localparam logic [DIGIT-1:0] SIGN_FLIP = DIGIT'(1) << (DIGIT - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [KW-1:0]    k_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic [DIGIT-1:0] top_a_s;
  logic [DIGIT-1:0] top_b_s;
  logic [DIGIT-1:0] cmp_x_s;
  logic [DIGIT-1:0] cmp_y_s;
  logic             dig_gt_s;
  logic             dig_eq_s;
  logic             last_s;

  // Select the current top digits and apply the sign flip to digit 0 in signed mode.
  always_comb begin
    top_a_s = a_q[WIDTH-1 -: DIGIT];
    top_b_s = b_q[WIDTH-1 -: DIGIT];
    last_s  = (k_q == K_LAST);
    if (signed_q && (k_q == KW'(0))) begin
      cmp_x_s = top_a_s ^ SIGN_FLIP;
      cmp_y_s = top_b_s ^ SIGN_FLIP;
    end else begin
      cmp_x_s = top_a_s;
      cmp_y_s = top_b_s;
    end
  end

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .x    (cmp_x_s),
    .y    (cmp_y_s),
    .x_gt (dig_gt_s),
    .x_eq (dig_eq_s)
  );

  // Control FSM, including the digit counter, operand shift registers and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only a resolving SCAN edge raises it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SCAN: begin
          if (!dig_eq_s) begin
            // First differing digit decides the whole compare.
            gt_q    <= dig_gt_s;
            lt_q    <= ~dig_gt_s;
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (last_s) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q     <= a_q << DIGIT;
            b_q     <= b_q << DIGIT;
            k_q     <= k_q + KW'(1);
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule : serial_magnitude_compare

// File: tb/tb_serial_magnitude_compare.sv
// ---------------------------------------------------------------------------
// tb_serial_magnitude_compare
//
// Directed, table-driven bench for the serial magnitude comparator.
// It also runs hand-written sequences for these cases:
//   - held start with operands changing during the scan,
//   - reset asserted in the middle of a scan.
// Latency is counted in clock edges from the accept edge to the edge that
// raises done (k+1 for a result resolved at digit k).
// ---------------------------------------------------------------------------
module tb_serial_magnitude_compare;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        gt;
  logic        lt;
  logic        eq;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic        sm;
    logic        egt;
    logic        elt;
    logic        eeq;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  serial_magnitude_compare #(
    .WIDTH (32),
    .DIGIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Wait for done, bounded.
  // Returns the number of edges waited and whether busy stayed high until done.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n = n + 1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   n;
    logic bok;
    @(negedge clk);
    a = v.av;
    b = v.bv;
    signed_mode = v.sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("v%0d_busy_on_accept", idx), {31'd0, busy}, 32'd1);
    wait_done(n, bok);
    chk($sformatf("v%0d_latency", idx), n, v.lat);
    chk($sformatf("v%0d_busy_during_scan", idx), {31'd0, bok}, 32'd1);
    chk($sformatf("v%0d_flags_gt_lt_eq", idx), {29'd0, gt, lt, eq}, {29'd0, v.egt, v.elt, v.eeq});
    chk($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_pulse_width", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_flags_held", idx), {29'd0, gt, lt, eq}, {29'd0, v.egt, v.elt, v.eeq});
  endtask

  initial begin
    int   n;
    logic bok;
    checks = 0;
    failures = 0;

    //              a              b              sm    gt    lt    eq    lat
    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[1]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[2]  = '{32'h00000009, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0, 8};
    vecs[3]  = '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 8};
    vecs[4]  = '{32'hFF98967F, 32'hFB98967F, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 8};
    vecs[10] = '{32'h12340000, 32'h12300000, 1'b0, 1'b1, 1'b0, 1'b0, 4};

    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // Start held high while the operands change during the scan.
    @(negedge clk);
    a = 32'h00000005;
    b = 32'h00000003;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_busy_on_accept", {31'd0, busy}, 32'd1);
    a = 32'h00000000;
    b = 32'hFFFFFFFF;
    wait_done(n, bok);
    chk("hold_first_latency", n, 32'd8);
    chk("hold_first_flags", {29'd0, gt, lt, eq}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("hold_busy_at_done", {31'd0, busy}, 32'd0);
    a = 32'h10000000;
    b = 32'h20000000;
    @(posedge clk);
    #1;
    chk("hold_reaccept_busy", {31'd0, busy}, 32'd1);
    chk("hold_reaccept_done_low", {31'd0, done}, 32'd0);
    chk("hold_flags_kept_on_accept", {29'd0, gt, lt, eq}, {29'd0, 1'b1, 1'b0, 1'b0});
    a = 32'hFFFFFFFF;
    b = 32'h00000000;
    wait_done(n, bok);
    chk("hold_second_latency", n, 32'd1);
    chk("hold_second_flags", {29'd0, gt, lt, eq}, {29'd0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_no_accept_after_release", {30'd0, busy, done}, 32'd0);

    // Reset asserted on the edge that would resolve digit k=3 of an equal scan.
    @(negedge clk);
    a = 32'hA5A5A5A5;
    b = 32'hA5A5A5A5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_scan_busy", {31'd0, busy}, 32'd1);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_scan_no_done_k%0d", e), {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_scan_outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_after_quiet_%0d", e), {27'd0, busy, done, gt, lt, eq}, 32'd0);
    end
    run_vec(100, vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_magnitude_compare
